// File: rtl/duck_pkg.sv
// Shared types and helpers for the multi-duck motion controller.
// Position values are unsigned fixed point: POS_INT_W integer bits over FRAC fraction bits.
package duck_pkg;

    localparam int POS_INT_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP_R,
        S_UP_L,
        S_DN_R,
        S_DN_L,
        S_KILLED,
        S_FLEE
    } duck_state_t;

    // A seed that would put the sprite past the right edge is pulled back by one sprite width.
    function automatic logic [POS_INT_W-1:0] spawn_fold(input logic [9:0] seed,
                                                        input int lim,
                                                        input int w);
        int s;
        s = int'({22'd0, seed});
        if (s >= lim) begin
            s = s - w;
        end
        return POS_INT_W'(s);
    endfunction

    function automatic duck_state_t fly_state(input logic up, input logic left);
        if (up) begin
            return left ? S_UP_L : S_UP_R;
        end
        return left ? S_DN_L : S_DN_R;
    endfunction

endpackage

// File: rtl/duck_channel.sv
// One duck: flight FSM with wall/ground bounce, kill-fall, timed flee and event pulses.
// All arithmetic is one bit wider than the position so borrows and overruns are visible.
module duck_channel
    import duck_pkg::*;
#(
    parameter int FRAC         = 24,
    parameter int GROUND       = 620,
    parameter int X_MAX        = 1024,
    parameter int DUCK_W       = 96,
    parameter int DUCK_H       = 32,
    parameter int X_SPEED      = 150,
    parameter int Y_SPEED      = 140,
    parameter int DEAD_SPEED   = 90,
    parameter int ESCAPE_TICKS = 2**26,
    parameter int CH_IDX       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_enable,
    input  logic                 spawn_grant,
    input  logic                 target_killed,
    input  logic [9:0]           lfsr_number,
    input  logic [1:0]           speed_level,
    output logic [POS_INT_W-1:0] xpos,
    output logic [POS_INT_W-1:0] ypos,
    output logic                 duck_direction,
    output logic                 duck_fell,
    output logic                 duck_escaped
);

    localparam int PW  = POS_INT_W + FRAC;
    localparam int EW  = PW + 1;
    localparam int ROT = (3 * CH_IDX) % 10;
    localparam int TW  = (ESCAPE_TICKS > 1) ? $clog2(ESCAPE_TICKS + 1) : 1;
    localparam bit ESC_EN = (ESCAPE_TICKS != 0);

    localparam logic [EW-1:0] X_LIM     = EW'(X_MAX - DUCK_W) << FRAC;
    localparam logic [EW-1:0] Y_LIM     = EW'(GROUND - DUCK_H) << FRAC;
    localparam logic [PW-1:0] Y_GND     = PW'(GROUND) << FRAC;
    localparam logic [PW-1:0] X_RST     = PW'(512) << FRAC;
    localparam logic [EW-1:0] DEAD_STEP = EW'(DEAD_SPEED);
    localparam logic [TW-1:0] ESC_T     = TW'(ESCAPE_TICKS);

    duck_state_t   state_reg, state_next;
    logic [PW-1:0] x_reg, x_next;
    logic [PW-1:0] y_reg, y_next;
    logic [1:0]    lvl_reg, lvl_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          dir_reg, dir_next;
    logic          fell_reg, fell_next;
    logic          esc_reg, esc_next;

    logic [EW-1:0] x_step, y_step;
    logic [EW-1:0] x_sub, x_add, y_sub, y_add, y_dead;
    logic [19:0]   seed_dbl;
    logic [9:0]    seed;
    logic          left_n, up_n;

    assign x_step = EW'(X_SPEED) << lvl_reg;
    assign y_step = EW'(Y_SPEED) << lvl_reg;
    assign x_sub  = {1'b0, x_reg} - x_step;
    assign x_add  = {1'b0, x_reg} + x_step;
    assign y_sub  = {1'b0, y_reg} - y_step;
    assign y_add  = {1'b0, y_reg} + y_step;
    assign y_dead = {1'b0, y_reg} + DEAD_STEP;

    // Each channel sees the shared seed rotated differently so simultaneous spawns spread out.
    assign seed_dbl = {lfsr_number, lfsr_number};
    assign seed     = seed_dbl[19-ROT -: 10];

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        lvl_next   = lvl_reg;
        timer_next = timer_reg;
        dir_next   = dir_reg;
        fell_next  = 1'b0;
        esc_next   = 1'b0;
        left_n     = (state_reg == S_UP_L) || (state_reg == S_DN_L);
        up_n       = (state_reg == S_UP_L) || (state_reg == S_UP_R);

        case (state_reg)
            S_IDLE: begin
                if (spawn_grant) begin
                    state_next = S_SPAWN;
                    x_next     = PW'(spawn_fold(seed, X_MAX - DUCK_W, DUCK_W)) << FRAC;
                    y_next     = Y_LIM[PW-1:0];
                    lvl_next   = speed_level;
                    timer_next = '0;
                end
            end
            S_SPAWN: begin
                left_n     = x_reg[PW-1:FRAC] >= POS_INT_W'(X_MAX / 2);
                dir_next   = left_n;
                state_next = left_n ? S_UP_L : S_UP_R;
            end
            S_UP_R, S_UP_L, S_DN_R, S_DN_L: begin
                if (target_killed) begin
                    state_next = S_KILLED;
                end else if (ESC_EN && timer_reg == ESC_T) begin
                    state_next = S_FLEE;
                end else begin
                    if (ESC_EN) begin
                        timer_next = timer_reg + TW'(1);
                    end
                    if (left_n) begin
                        if (x_sub[EW-1]) begin
                            x_next = '0;
                            left_n = 1'b0;
                        end else begin
                            x_next = x_sub[PW-1:0];
                        end
                    end else if (x_add >= X_LIM) begin
                        x_next = X_LIM[PW-1:0];
                        left_n = 1'b1;
                    end else begin
                        x_next = x_add[PW-1:0];
                    end
                    if (up_n) begin
                        if (y_sub[EW-1] || y_sub[PW-1:FRAC] == '0) begin
                            y_next = '0;
                            up_n   = 1'b0;
                        end else begin
                            y_next = y_sub[PW-1:0];
                        end
                    end else if (y_add >= Y_LIM) begin
                        y_next = Y_LIM[PW-1:0];
                        up_n   = 1'b1;
                    end else begin
                        y_next = y_add[PW-1:0];
                    end
                    state_next = fly_state(up_n, left_n);
                    dir_next   = left_n;
                end
            end
            S_KILLED: begin
                // Landing is evaluated on the stepped value, so a held kill never stalls the fall.
                if (y_dead >= Y_LIM) begin
                    y_next     = Y_GND;
                    fell_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    y_next = y_dead[PW-1:0];
                end
            end
            S_FLEE: begin
                if (target_killed) begin
                    state_next = S_KILLED;
                end else if (y_sub[EW-1] || y_sub[PW-1:FRAC] == '0) begin
                    y_next     = '0;
                    esc_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    y_next = y_sub[PW-1:0];
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides everything: park on the ground, keep x, drop any pending pulse.
        if (!game_enable) begin
            state_next = S_IDLE;
            x_next     = x_reg;
            y_next     = Y_GND;
            lvl_next   = lvl_reg;
            timer_next = '0;
            dir_next   = dir_reg;
            fell_next  = 1'b0;
            esc_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            x_reg     <= X_RST;
            y_reg     <= Y_GND;
            lvl_reg   <= '0;
            timer_reg <= '0;
            dir_reg   <= 1'b0;
            fell_reg  <= 1'b0;
            esc_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            lvl_reg   <= lvl_next;
            timer_reg <= timer_next;
            dir_reg   <= dir_next;
            fell_reg  <= fell_next;
            esc_reg   <= esc_next;
        end
    end

    assign xpos           = x_reg[PW-1:FRAC];
    assign ypos           = y_reg[PW-1:FRAC];
    assign duck_direction = dir_reg;
    assign duck_fell      = fell_reg;
    assign duck_escaped   = esc_reg;

endmodule

// File: rtl/duck_flock_ctl.sv
// Multi-duck motion controller: a rotating spawn token plus N_DUCKS independent duck channels.
// Per-duck outputs are packed 12 bits per duck, duck i at [12*i +: 12].
module duck_flock_ctl
    import duck_pkg::*;
#(
    parameter int N_DUCKS      = 2,
    parameter int FRAC         = 24,
    parameter int GROUND       = 620,
    parameter int X_MAX        = 1024,
    parameter int DUCK_W       = 96,
    parameter int DUCK_H       = 32,
    parameter int X_SPEED      = 150,
    parameter int Y_SPEED      = 140,
    parameter int DEAD_SPEED   = 90,
    parameter int ESCAPE_TICKS = 2**26
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           game_enable,
    input  logic [N_DUCKS-1:0]             target_killed,
    input  logic [9:0]                     lfsr_number,
    input  logic [1:0]                     speed_level,
    output logic [N_DUCKS*POS_INT_W-1:0]   xpos,
    output logic [N_DUCKS*POS_INT_W-1:0]   ypos,
    output logic [N_DUCKS-1:0]             duck_direction,
    output logic [N_DUCKS-1:0]             duck_fell,
    output logic [N_DUCKS-1:0]             duck_escaped
);

    localparam int TOK_W = (N_DUCKS > 1) ? $clog2(N_DUCKS) : 1;

    logic [TOK_W-1:0] token_reg, token_next;

    // Only the channel holding the token may leave IDLE, so at most one spawn happens per clock.
    always_comb begin
        token_next = token_reg;
        if (game_enable) begin
            token_next = (token_reg == TOK_W'(N_DUCKS - 1)) ? '0 : token_reg + TOK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token_reg <= '0;
        end else begin
            token_reg <= token_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_DUCKS; gi++) begin : g_duck
            logic spawn_grant;
            assign spawn_grant = game_enable && (token_reg == TOK_W'(gi));

            duck_channel #(
                .FRAC         (FRAC),
                .GROUND       (GROUND),
                .X_MAX        (X_MAX),
                .DUCK_W       (DUCK_W),
                .DUCK_H       (DUCK_H),
                .X_SPEED      (X_SPEED),
                .Y_SPEED      (Y_SPEED),
                .DEAD_SPEED   (DEAD_SPEED),
                .ESCAPE_TICKS (ESCAPE_TICKS),
                .CH_IDX       (gi)
            ) u_channel (
                .clk            (clk),
                .rst            (rst),
                .game_enable    (game_enable),
                .spawn_grant    (spawn_grant),
                .target_killed  (target_killed[gi]),
                .lfsr_number    (lfsr_number),
                .speed_level    (speed_level),
                .xpos           (xpos[POS_INT_W*gi +: POS_INT_W]),
                .ypos           (ypos[POS_INT_W*gi +: POS_INT_W]),
                .duck_direction (duck_direction[gi]),
                .duck_fell      (duck_fell[gi]),
                .duck_escaped   (duck_escaped[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_duck_flock_ctl.sv
// Randomised bench for duck_flock_ctl: two instances (escape off / escape after 50 clks) share stimulus,
// a pixel-level flock model predicts every cycle, and a monitor compares against a queue of predictions.
module tb_duck_flock_ctl;

    localparam int N     = 2;
    localparam int FRAC  = 24;
    localparam int ONE   = 1 << FRAC;
    localparam int ESC_T = 50;
    localparam int GND   = 620;
    localparam int TOP_Y = 588;
    localparam int XLIM  = 928;
    localparam int N_CYC = 20000;

    localparam int P_IDLE  = 0;
    localparam int P_SPAWN = 1;
    localparam int P_FLY   = 2;
    localparam int P_FALL  = 3;
    localparam int P_FLEE  = 4;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        dir;
        logic        fell;
        logic        esc;
    } duck_obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          game_enable = 1'b0;
    logic [N-1:0]  target_killed = '0;
    logic [9:0]    lfsr_number = '0;
    logic [1:0]    speed_level = '0;

    logic [N*12-1:0] xpos0, ypos0, xpos1, ypos1;
    logic [N-1:0]    dir0, fell0, esc0, dir1, fell1, esc1;

    duck_flock_ctl #(
        .N_DUCKS(N), .FRAC(FRAC), .GROUND(GND), .X_MAX(1024), .DUCK_W(96), .DUCK_H(32),
        .X_SPEED(ONE), .Y_SPEED(ONE), .DEAD_SPEED(ONE), .ESCAPE_TICKS(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .game_enable(game_enable), .target_killed(target_killed),
        .lfsr_number(lfsr_number), .speed_level(speed_level),
        .xpos(xpos0), .ypos(ypos0), .duck_direction(dir0), .duck_fell(fell0), .duck_escaped(esc0)
    );

    duck_flock_ctl #(
        .N_DUCKS(N), .FRAC(FRAC), .GROUND(GND), .X_MAX(1024), .DUCK_W(96), .DUCK_H(32),
        .X_SPEED(ONE), .Y_SPEED(ONE), .DEAD_SPEED(ONE), .ESCAPE_TICKS(ESC_T)
    ) u_dut1 (
        .clk(clk), .rst(rst), .game_enable(game_enable), .target_killed(target_killed),
        .lfsr_number(lfsr_number), .speed_level(speed_level),
        .xpos(xpos1), .ypos(ypos1), .duck_direction(dir1), .duck_fell(fell1), .duck_escaped(esc1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    duck_obs_t exp_q[$];

    // Model state in whole pixels: every speed is exactly one pixel, so fractions stay zero.
    int m_phase[2][2];
    int m_x[2][2];
    int m_y[2][2];
    int m_left[2][2];
    int m_up[2][2];
    int m_dir[2][2];
    int m_lvl[2][2];
    int m_timer[2][2];
    int m_fell[2][2];
    int m_esc[2][2];
    int m_token[2];
    int esc_ticks[2] = '{0, ESC_T};

    function automatic duck_obs_t observe(int d, int i);
        duck_obs_t o;
        if (d == 0) begin
            o.x = xpos0[12*i +: 12]; o.y = ypos0[12*i +: 12];
            o.dir = dir0[i]; o.fell = fell0[i]; o.esc = esc0[i];
        end else begin
            o.x = xpos1[12*i +: 12]; o.y = ypos1[12*i +: 12];
            o.dir = dir1[i]; o.fell = fell1[i]; o.esc = esc1[i];
        end
        return o;
    endfunction

    task automatic chk(input string name, input int d, input int i, input duck_obs_t got, input duck_obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d duck%0d cyc %0d: got x=%0d y=%0d dir=%0b fell=%0b esc=%0b, expected x=%0d y=%0d dir=%0b fell=%0b esc=%0b",
                     name, d, i, cyc, got.x, got.y, got.dir, got.fell, got.esc,
                     exp.x, exp.y, exp.dir, exp.fell, exp.esc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_token[d] = 0;
            for (int i = 0; i < 2; i++) begin
                m_phase[d][i] = P_IDLE; m_x[d][i] = 512; m_y[d][i] = GND;
                m_left[d][i] = 0; m_up[d][i] = 0; m_dir[d][i] = 0; m_lvl[d][i] = 0;
                m_timer[d][i] = 0; m_fell[d][i] = 0; m_esc[d][i] = 0;
            end
        end
    endtask

    task automatic model_step(input bit ge, input logic [1:0] tk, input int lfsr, input int lvl);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                int s, nx, ny, r, seed;
                m_fell[d][i] = 0;
                m_esc[d][i]  = 0;
                s = 1 << m_lvl[d][i];
                if (!ge) begin
                    m_phase[d][i] = P_IDLE; m_y[d][i] = GND; m_timer[d][i] = 0;
                end else begin
                    case (m_phase[d][i])
                        P_IDLE: if (m_token[d] == i) begin
                            r = (3 * i) % 10;
                            seed = ((lfsr << r) | (lfsr >> (10 - r))) & 1023;
                            m_x[d][i] = (seed >= XLIM) ? seed - 96 : seed;
                            m_y[d][i] = TOP_Y;
                            m_lvl[d][i] = lvl;
                            m_timer[d][i] = 0;
                            m_phase[d][i] = P_SPAWN;
                        end
                        P_SPAWN: begin
                            m_left[d][i] = (m_x[d][i] >= 512) ? 1 : 0;
                            m_up[d][i] = 1;
                            m_dir[d][i] = m_left[d][i];
                            m_phase[d][i] = P_FLY;
                        end
                        P_FLY: begin
                            if (tk[i]) begin
                                m_phase[d][i] = P_FALL;
                            end else if (esc_ticks[d] != 0 && m_timer[d][i] == esc_ticks[d]) begin
                                m_phase[d][i] = P_FLEE;
                            end else begin
                                m_timer[d][i]++;
                                if (m_left[d][i] != 0) begin
                                    nx = m_x[d][i] - s;
                                    if (nx < 0) begin m_x[d][i] = 0; m_left[d][i] = 0; end
                                    else m_x[d][i] = nx;
                                end else begin
                                    nx = m_x[d][i] + s;
                                    if (nx >= XLIM) begin m_x[d][i] = XLIM; m_left[d][i] = 1; end
                                    else m_x[d][i] = nx;
                                end
                                if (m_up[d][i] != 0) begin
                                    ny = m_y[d][i] - s;
                                    if (ny <= 0) begin m_y[d][i] = 0; m_up[d][i] = 0; end
                                    else m_y[d][i] = ny;
                                end else begin
                                    ny = m_y[d][i] + s;
                                    if (ny >= TOP_Y) begin m_y[d][i] = TOP_Y; m_up[d][i] = 1; end
                                    else m_y[d][i] = ny;
                                end
                                m_dir[d][i] = m_left[d][i];
                            end
                        end
                        P_FALL: begin
                            ny = m_y[d][i] + 1;
                            if (ny >= TOP_Y) begin
                                m_y[d][i] = GND; m_fell[d][i] = 1; m_phase[d][i] = P_IDLE;
                            end else m_y[d][i] = ny;
                        end
                        default: begin
                            if (tk[i]) begin
                                m_phase[d][i] = P_FALL;
                            end else begin
                                ny = m_y[d][i] - s;
                                if (ny <= 0) begin
                                    m_y[d][i] = 0; m_esc[d][i] = 1; m_phase[d][i] = P_IDLE;
                                end else m_y[d][i] = ny;
                            end
                        end
                    endcase
                end
            end
            if (ge) m_token[d] = (m_token[d] + 1) % 2;
        end
    endtask

    // One clock: the model advances with the inputs seen at the edge and its prediction is queued.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(game_enable, target_killed, int'(lfsr_number), int'(speed_level));
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                duck_obs_t e;
                e.x = 12'(m_x[d][i]); e.y = 12'(m_y[d][i]);
                e.dir = m_dir[d][i][0]; e.fell = m_fell[d][i][0]; e.esc = m_esc[d][i][0];
                exp_q.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Monitor: every prediction is checked on the falling edge after its clock.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() >= 4) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 2; i++) begin
                        duck_obs_t e, g;
                        e = exp_q.pop_front();
                        g = observe(d, i);
                        chk("cycle", d, i, g, e);
                        if (g.fell) $display("cyc %0d dut%0d duck%0d fell at x=%0d", cyc, d, i, g.x);
                        if (g.esc) $display("cyc %0d dut%0d duck%0d escaped at x=%0d", cyc, d, i, g.x);
                    end
                end
            end
        end
    end

    initial begin
        int ge_off;
        int kill_hold[2];
        duck_obs_t rst_exp;
        ge_off = 0;
        kill_hold[0] = 0;
        kill_hold[1] = 0;
        rst_exp.x = 12'd512; rst_exp.y = 12'd620; rst_exp.dir = 1'b0; rst_exp.fell = 1'b0; rst_exp.esc = 1'b0;
        model_reset();

        cycle();
        cycle();
        rst = 1'b0;

        // First spawn from a seed past the fold point, then a low seed for the second duck.
        game_enable = 1'b1; lfsr_number = 10'd1000; speed_level = 2'd0;
        cycle();
        lfsr_number = 10'd100;
        cycle();

        for (int c = 0; c < N_CYC; c++) begin
            if (c == 7000) begin
                #2 rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < 2; i++)
                        chk("async_reset", d, i, observe(d, i), rst_exp);
                model_reset();
                cycle();
                rst = 1'b0;
            end
            if (ge_off > 0) begin
                game_enable = 1'b0;
                ge_off--;
            end else begin
                game_enable = 1'b1;
                if ($urandom_range(0, 2999) == 0) ge_off = $urandom_range(1, 6);
            end
            for (int i = 0; i < 2; i++) begin
                if (kill_hold[i] > 0) begin
                    target_killed[i] = 1'b1;
                    kill_hold[i]--;
                end else begin
                    target_killed[i] = 1'b0;
                    if ($urandom_range(0, 1199) == 0) kill_hold[i] = $urandom_range(1, 40);
                end
            end
            lfsr_number = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 99) == 0) speed_level = 2'($urandom_range(0, 3));
            cycle();
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
